// File: rtl/seg7_scroll_ctrl.sv
// seg7_scroll_ctrl: bus-mapped scroller that drives a sliding 4-digit window into the 7-segment peripheral.
// Optional register readback is enabled by defining SEG7_SCROLL_READBACK_EN.
module seg7_scroll_ctrl #(
    parameter logic [31:0] BASE = 32'h20,
    parameter logic [31:0] SEG_BASE = 32'h10,
    parameter int PERIOD_BITS = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        strobe,
    input  logic        rw,
    input  logic [31:0] addr,
    input  logic [31:0] d_in,
    output logic [31:0] d_out,
    output logic        m_strobe,
    output logic        m_rw,
    output logic [31:0] m_addr,
    output logic [31:0] m_data,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, COUNT, WR_DIG_A, WR_DIG_B, WR_DOT_A, WR_DOT_B} state_t;
    state_t state, state_d;
    logic [63:0] msg, msg_d;
    logic [9:0] ctrl, ctrl_d;
    logic [PERIOD_BITS-1:0] period, period_d, timer, timer_d, eff;
    logic [3:0] pos, pos_d, dots;
    logic [15:0] win;
    logic sel, wr, ctrl_wr, go, step, dig, dot;

    function automatic logic [15:0] window(input logic [63:0] m, input logic [3:0] lm1, input logic [3:0] p);
        logic [15:0] w;
        logic [3:0] idx;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            idx = 4'((5'(p) + 5'(k)) % (5'(lm1) + 5'd1));
            w[15-4*k -: 4] = m[4*idx +: 4];
        end
        return w;
    endfunction

    // ctrl packs {dir, dots, len-1, enable}
    always_comb begin
        sel = strobe && addr[31:2] == BASE[31:2];
        wr = sel && rw;
        ctrl_wr = wr && addr[1:0] == 2'd2;
        msg_d = {wr && addr[1:0] == 2'd1 ? d_in : msg[63:32], wr && addr[1:0] == 2'd0 ? d_in : msg[31:0]};
        ctrl_d = ctrl_wr ? {d_in[12:4], d_in[0]} : ctrl;
        period_d = wr && addr[1:0] == 2'd3 ? d_in[PERIOD_BITS-1:0] : period;
        eff = period < PERIOD_BITS'(8) ? PERIOD_BITS'(8) : period;
        go = ctrl_wr && d_in[0];
        step = ctrl[0] && !ctrl_wr && timer >= eff - PERIOD_BITS'(1);
        pos_d = go ? 4'd0 : step ? 4'((5'(pos) + (ctrl[9] ? 5'(ctrl[4:1]) : 5'd1)) % (5'(ctrl[4:1]) + 5'd1)) : pos;
        timer_d = go || step || !ctrl_d[0] ? '0 : timer + 1'b1;
        state_d = go || step ? WR_DIG_A :
                  !ctrl_d[0] ? IDLE :
                  state == WR_DIG_A ? WR_DIG_B :
                  state == WR_DIG_B ? WR_DOT_A :
                  state == WR_DOT_A ? WR_DOT_B :
                  state == WR_DOT_B ? COUNT : state;
        dig = state == WR_DIG_A || state == WR_DIG_B;
        dot = state == WR_DOT_A || state == WR_DOT_B;
        m_strobe = dig || dot;
        m_rw = dig || dot;
        busy = dig || dot;
        m_addr = dot ? SEG_BASE + 32'd1 : SEG_BASE;
        m_data = dig ? {16'b0, win} : dot ? {28'b0, dots} : '0;
    end

    // The window is latched from the values the registers take on entry to WR_DIG_A
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            msg <= '0;
            ctrl <= '0;
            period <= '0;
            timer <= '0;
            pos <= '0;
            win <= '0;
            dots <= '0;
        end else begin
            state <= state_d;
            msg <= msg_d;
            ctrl <= ctrl_d;
            period <= period_d;
            timer <= timer_d;
            pos <= pos_d;
            if (go || step) begin
                win <= window(msg_d, ctrl_d[4:1], pos_d);
                dots <= ctrl_d[8:5];
            end
        end
    end

`ifdef SEG7_SCROLL_READBACK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            d_out <= '0;
        else if (sel && !rw)
            d_out <= addr[1:0] == 2'd0 ? msg[31:0] :
                     addr[1:0] == 2'd1 ? msg[63:32] :
                     addr[1:0] == 2'd2 ? {19'b0, ctrl[9:1], 3'b0, ctrl[0]} : 32'(period);
    end
`else
    assign d_out = '0;
`endif
endmodule
